pe_dot_scheduler: RTL and testbench

- Sequencing controller that computes a dot product of cfg_len 8-bit operand pairs on one multi-cycle PE multiplier.
- Buffers incoming operand pairs in an internal FIFO, then issues them one at a time to the PE using the PE's en/done handshake.
- Accumulates each 16-bit product and returns the sum through a valid/ready result port.
- Sits between the host/loader and a single PE; it is the building block for row controllers of the PE array.

---
 rtl/pe_dot_scheduler_if.sv | 44 ++++
 rtl/pe_dot_scheduler.sv | 148 ++++++++++++++
 tb/tb_pe_dot_scheduler.sv | 455 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pe_dot_scheduler_if.sv
// Handshake bundle for pe_dot_scheduler: job control, operand stream, PE port, result port.
// res_ovf exists only when ACC_SAT_EN is defined.
interface pe_dot_scheduler_if #(
  parameter int DEPTH = 8,
  parameter int LEN_W = 8,
  parameter int ACC_W = 32
);
  logic                       start;
  logic [LEN_W-1:0]           cfg_len;
  logic                       busy;
  logic                       in_valid;
  logic                       in_ready;
  logic [7:0]                 in_a;
  logic [7:0]                 in_b;
  logic                       pe_en;
  logic [7:0]                 pe_a;
  logic [7:0]                 pe_b;
  logic                       pe_done;
  logic [15:0]                pe_c;
  logic                       res_valid;
  logic                       res_ready;
  logic [ACC_W-1:0]           res_data;
  logic [LEN_W-1:0]           res_count;
  logic [$clog2(DEPTH):0]     fifo_level;
`ifdef ACC_SAT_EN
  logic                       res_ovf;
`endif

  modport slave (
    input  start, cfg_len, in_valid, in_a, in_b, pe_done, pe_c, res_ready,
    output busy, in_ready, pe_en, pe_a, pe_b, res_valid, res_data, res_count, fifo_level
`ifdef ACC_SAT_EN
    , output res_ovf
`endif
  );

  modport master (
    output start, cfg_len, in_valid, in_a, in_b, pe_done, pe_c, res_ready,
    input  busy, in_ready, pe_en, pe_a, pe_b, res_valid, res_data, res_count, fifo_level
`ifdef ACC_SAT_EN
    , input res_ovf
`endif
  );
endinterface

// File: rtl/pe_dot_scheduler.sv
// Dot-product sequencer: buffers operand pairs, feeds them one at a time to a multi-cycle PE,
// accumulates the products. Optional macro ACC_SAT_EN: saturating accumulator with sticky res_ovf.
module pe_dot_scheduler #(
  parameter int DEPTH = 8,
  parameter int LEN_W = 8,
  parameter int ACC_W = 32
) (
  input logic               clk,
  input logic               rst,
  pe_dot_scheduler_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, FETCH, ISSUE, RESULT} state_t;

  state_t state, state_next;

  logic [15:0]      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [LVL_W-1:0] level;
  logic             full, empty, push, pop;

  logic             load, accum;
  logic [LEN_W-1:0] len, cnt, cnt_inc;
  logic [ACC_W-1:0] acc;
  logic [7:0]       op_a, op_b;

  assign full    = (level == LVL_W'(DEPTH));
  assign empty   = (level == '0);
  assign push    = bus.in_valid & ~full;
  assign cnt_inc = cnt + LEN_W'(1);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    load       = 1'b0;
    accum      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          load       = 1'b1;
          state_next = (bus.cfg_len == '0) ? RESULT : FETCH;
        end
      end
      FETCH: begin
        if (!empty) begin
          pop        = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.pe_done) begin
          accum      = 1'b1;
          state_next = (cnt_inc == len) ? RESULT : FETCH;
        end
      end
      RESULT: begin
        if (bus.res_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Storage is not reset; occupancy and pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {bus.in_a, bus.in_b};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

`ifdef ACC_SAT_EN
  logic             ovf;
  logic [ACC_W:0]   sum;
  assign sum = {1'b0, acc} + (ACC_W+1)'(bus.pe_c);
`else
  logic [ACC_W-1:0] sum;
  assign sum = acc + ACC_W'(bus.pe_c);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      len  <= '0;
      cnt  <= '0;
      acc  <= '0;
      op_a <= '0;
      op_b <= '0;
`ifdef ACC_SAT_EN
      ovf  <= 1'b0;
`endif
    end else begin
      if (load) begin
        len <= bus.cfg_len;
        cnt <= '0;
        acc <= '0;
`ifdef ACC_SAT_EN
        ovf <= 1'b0;
`endif
      end
      if (pop) {op_a, op_b} <= mem[rd_ptr];
      if (accum) begin
        cnt <= cnt_inc;
`ifdef ACC_SAT_EN
        if (sum[ACC_W]) begin
          acc <= '1;
          ovf <= 1'b1;
        end else begin
          acc <= sum[ACC_W-1:0];
        end
`else
        acc <= sum;
`endif
      end
    end
  end

  assign bus.busy       = (state != IDLE);
  assign bus.in_ready   = ~full;
  assign bus.pe_en      = (state == ISSUE);
  assign bus.pe_a       = op_a;
  assign bus.pe_b       = op_b;
  assign bus.res_valid  = (state == RESULT);
  assign bus.res_data   = acc;
  assign bus.res_count  = cnt;
  assign bus.fifo_level = level;
`ifdef ACC_SAT_EN
  assign bus.res_ovf    = ovf;
`endif
endmodule

// File: tb/tb_pe_dot_scheduler.sv
// Self-checking bench for pe_dot_scheduler: random-latency PE model, queue-based reference model.
// A second, 16-bit accumulator instance covers wrap (or saturation under ACC_SAT_EN).
module tb_pe_dot_scheduler;
  localparam int DEPTH  = 8;
  localparam int LEN_W  = 8;
  localparam int ACC_W  = 32;
  localparam int ACC2_W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pe_dot_scheduler_if #(.DEPTH(DEPTH), .LEN_W(LEN_W), .ACC_W(ACC_W))  bus ();
  pe_dot_scheduler_if #(.DEPTH(DEPTH), .LEN_W(LEN_W), .ACC_W(ACC2_W)) bus2 ();

  pe_dot_scheduler #(.DEPTH(DEPTH), .LEN_W(LEN_W), .ACC_W(ACC_W))  dut  (.clk(clk), .rst(rst), .bus(bus));
  pe_dot_scheduler #(.DEPTH(DEPTH), .LEN_W(LEN_W), .ACC_W(ACC2_W)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] q_a[$];
  logic [7:0] q_b[$];

  // PE model: random latency, flags operand instability or pe_en lingering after done
  logic        model_done = 1'b0;
  logic        done_d     = 1'b0;
  logic [15:0] model_c    = '0;
  logic        pe_busy    = 1'b0;
  int          pe_wait    = 0;
  logic [7:0]  lat_a      = '0;
  logic [7:0]  lat_b      = '0;
  int          pe_rises   = 0;
  int          pe_bad     = 0;
  logic        prev_en    = 1'b0;
  logic        stray_done = 1'b0;
  logic [15:0] stray_c    = '0;

  assign bus.pe_done = model_done | stray_done;
  assign bus.pe_c    = model_done ? model_c : stray_c;

  always @(posedge clk) begin
    model_done <= 1'b0;
    done_d     <= model_done;
    prev_en    <= bus.pe_en;
    if (bus.pe_en && !prev_en) pe_rises <= pe_rises + 1;
    if (done_d && bus.pe_en) pe_bad <= pe_bad + 1;
    if (rst) begin
      pe_busy <= 1'b0;
    end else if (pe_busy) begin
      if (bus.pe_a !== lat_a || bus.pe_b !== lat_b || bus.pe_en !== 1'b1) pe_bad <= pe_bad + 1;
      if (pe_wait == 0) begin
        model_done <= 1'b1;
        model_c    <= lat_a * lat_b;
        pe_busy    <= 1'b0;
      end else begin
        pe_wait <= pe_wait - 1;
      end
    end else if (bus.pe_en && !model_done) begin
      pe_busy <= 1'b1;
      lat_a   <= bus.pe_a;
      lat_b   <= bus.pe_b;
      pe_wait <= $urandom_range(0, 3);
    end
  end

  function automatic logic [63:0] model_job(input int len);
    logic [63:0] s;
    logic [63:0] lim;
    s   = '0;
    lim = (64'd1 << ACC_W) - 64'd1;
    for (int i = 0; i < len; i++) begin
      s = s + 64'(q_a.pop_front()) * 64'(q_b.pop_front());
`ifdef ACC_SAT_EN
      if (s > lim) s = lim;
`else
      s = s & lim;
`endif
    end
    return s;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push(input logic [7:0] a, input logic [7:0] b);
    logic acc_ok;
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    acc_ok       = bus.in_ready;
    tick();
    bus.in_valid = 1'b0;
    if (acc_ok) begin
      q_a.push_back(a);
      q_b.push_back(b);
    end
  endtask

  task automatic start_job(input logic [LEN_W-1:0] len);
    bus.start   = 1'b1;
    bus.cfg_len = len;
    tick();
    bus.start   = 1'b0;
  endtask

  task automatic wait_result(input string name);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (bus.res_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: res_valid never rose", name);
    end
  endtask

  task automatic accept();
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    n_cmp++;
    if ({bus.busy, bus.in_ready, bus.pe_en, bus.res_valid, bus.fifo_level, bus.res_count, bus.pe_a, bus.pe_b}
        !== {1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0, 8'd0, 8'd0}) begin
      n_bad++;
      $display("FAIL reset_ctrl: got busy=%b in_ready=%b pe_en=%b res_valid=%b lvl=%0d cnt=%0d pe_a=%0d pe_b=%0d",
               bus.busy, bus.in_ready, bus.pe_en, bus.res_valid, bus.fifo_level, bus.res_count, bus.pe_a, bus.pe_b);
    end
    n_cmp++;
    if (bus.res_data !== '0) begin
      n_bad++;
      $display("FAIL reset_data: got %0d expected 0", bus.res_data);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int r0;
    push(8'd5, 8'd8); push(8'd2, 8'd5); push(8'd8, 8'd7); push(8'd4, 8'd5);
    n_cmp++;
    if (bus.fifo_level !== 4'd4) begin
      n_bad++;
      $display("FAIL basic_level: got %0d expected 4", bus.fifo_level);
    end
    r0 = pe_rises;
    start_job(8'd4);
    n_cmp++;
    if (bus.busy !== 1'b1) begin
      n_bad++;
      $display("FAIL basic_busy: got %b expected 1", bus.busy);
    end
    wait_result("basic");
    void'(model_job(4));
    n_cmp++;
    if (bus.res_data !== 32'd126 || bus.res_count !== 8'd4) begin
      n_bad++;
      $display("FAIL basic_sum: got %0d/%0d expected 126/4", bus.res_data, bus.res_count);
    end
    n_cmp++;
    if (pe_rises - r0 != 4) begin
      n_bad++;
      $display("FAIL basic_pe_en_edges: got %0d expected 4", pe_rises - r0);
    end
    accept();
    n_cmp++;
    if (bus.res_valid !== 1'b0 || bus.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_release: got res_valid=%b busy=%b expected 0/0", bus.res_valid, bus.busy);
    end
  endtask

  task automatic test_extremes();
    repeat (3) push(8'd255, 8'd255);
    push(8'd29, 8'd121);
    push(8'd221, 8'd237);
    start_job(8'd5);
    wait_result("extremes");
    void'(model_job(5));
    n_cmp++;
    if (bus.res_data !== 32'd250961 || bus.res_count !== 8'd5) begin
      n_bad++;
      $display("FAIL extremes_sum: got %0d/%0d expected 250961/5", bus.res_data, bus.res_count);
    end
    accept();
  endtask

  task automatic test_stall();
    logic [63:0] exp;
    logic        bad;
    start_job(8'd3);
    bad = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (bus.busy !== 1'b1 || bus.pe_en !== 1'b0) bad = 1'b1;
      tick();
    end
    n_cmp++;
    if (bad) begin
      n_bad++;
      $display("FAIL stall_empty: got busy=%b pe_en=%b expected 1/0", bus.busy, bus.pe_en);
    end
    for (int i = 0; i < 3; i++) push(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    exp = model_job(3);
    wait_result("stall");
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (bus.res_valid !== 1'b1 || bus.res_data !== exp[ACC_W-1:0] || bus.res_count !== 8'd3) bad = 1'b1;
      bus.start   = (i == 3);
      bus.cfg_len = '0;
      tick();
    end
    bus.start = 1'b0;
    n_cmp++;
    if (bad) begin
      n_bad++;
      $display("FAIL stall_hold: got %0d/%0d expected %0d/3 held", bus.res_data, bus.res_count, exp);
    end
    accept();
    bad = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (bus.res_valid !== 1'b0 || bus.busy !== 1'b0) bad = 1'b1;
      tick();
    end
    n_cmp++;
    if (bad) begin
      n_bad++;
      $display("FAIL stall_no_new_job: got res_valid=%b busy=%b expected 0/0", bus.res_valid, bus.busy);
    end
  endtask

  task automatic test_fill();
    logic [63:0] exp;
    for (int i = 0; i < DEPTH; i++) push(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    n_cmp++;
    if (bus.in_ready !== 1'b0 || bus.fifo_level !== 4'd8) begin
      n_bad++;
      $display("FAIL fill_full: got in_ready=%b lvl=%0d expected 0/8", bus.in_ready, bus.fifo_level);
    end
    push(8'd77, 8'd99);
    start_job(8'd8);
    exp = model_job(8);
    wait_result("fill");
    n_cmp++;
    if (bus.res_data !== exp[ACC_W-1:0] || bus.fifo_level !== 4'd0) begin
      n_bad++;
      $display("FAIL fill_drop: got sum=%0d lvl=%0d expected %0d/0", bus.res_data, bus.fifo_level, exp);
    end
    accept();
  endtask

  task automatic test_zero();
    start_job(8'd0);
    n_cmp++;
    if (bus.res_valid !== 1'b1 || bus.res_data !== '0 || bus.res_count !== '0) begin
      n_bad++;
      $display("FAIL zero_len: got valid=%b data=%0d cnt=%0d expected 1/0/0", bus.res_valid, bus.res_data, bus.res_count);
    end
    accept();
  endtask

  task automatic test_ignore();
    logic [63:0] exp;
    for (int i = 0; i < 3; i++) push(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    start_job(8'd2);
    exp = model_job(2);
    tick();
    bus.start   = 1'b1;
    bus.cfg_len = 8'd5;
    tick();
    bus.start   = 1'b0;
    wait_result("ignore");
    n_cmp++;
    if (bus.res_data !== exp[ACC_W-1:0] || bus.res_count !== 8'd2 || bus.fifo_level !== 4'd1) begin
      n_bad++;
      $display("FAIL ignore_start: got %0d/%0d lvl=%0d expected %0d/2 lvl=1", bus.res_data, bus.res_count, bus.fifo_level, exp);
    end
    accept();
    stray_c    = 16'hBEEF;
    stray_done = 1'b1;
    tick();
    stray_done = 1'b0;
    start_job(8'd1);
    exp = model_job(1);
    wait_result("stray");
    n_cmp++;
    if (bus.res_data !== exp[ACC_W-1:0] || bus.res_count !== 8'd1) begin
      n_bad++;
      $display("FAIL stray_done: got %0d/%0d expected %0d/1", bus.res_data, bus.res_count, exp);
    end
    accept();
  endtask

  task automatic test_random();
    logic [63:0] exp;
    int len, need, pre;
    logic bad;
    for (int it = 0; it < 20; it++) begin
      len  = $urandom_range(0, DEPTH);
      need = (len > q_a.size()) ? len - q_a.size() : 0;
      pre  = $urandom_range(0, need);
      for (int i = 0; i < pre; i++) push(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      start_job(LEN_W'(len));
      for (int i = pre; i < need; i++) begin
        repeat ($urandom_range(0, 4)) tick();
        push(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      end
      exp = model_job(len);
      wait_result("random");
      bad = 1'b0;
      repeat ($urandom_range(0, 3)) begin
        if (bus.res_valid !== 1'b1 || bus.res_data !== exp[ACC_W-1:0]) bad = 1'b1;
        tick();
      end
      n_cmp++;
      if (bad || bus.res_data !== exp[ACC_W-1:0] || bus.res_count !== LEN_W'(len)) begin
        n_bad++;
        $display("FAIL random_job%0d: got %0d/%0d expected %0d/%0d", it, bus.res_data, bus.res_count, exp, len);
      end
      accept();
    end
  endtask

  task automatic test_reset_mid();
    int r0;
    logic hit;
    q_a.delete();
    q_b.delete();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) push(8'($urandom_range(1, 255)), 8'($urandom_range(1, 255)));
    r0 = pe_rises;
    start_job(8'd4);
    hit = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (pe_rises - r0 == 2 && bus.pe_en === 1'b1) begin
        hit = 1'b1;
        break;
      end
      tick();
    end
    n_cmp++;
    if (!hit) begin
      n_bad++;
      $display("FAIL reset_mid_reach: got no second issue expected one");
    end
    rst = 1'b1;
    tick();
    n_cmp++;
    if ({bus.pe_en, bus.busy, bus.fifo_level, bus.res_valid} !== {1'b0, 1'b0, 4'd0, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_mid_state: got pe_en=%b busy=%b lvl=%0d res_valid=%b expected 0/0/0/0",
               bus.pe_en, bus.busy, bus.fifo_level, bus.res_valid);
    end
    rst = 1'b0;
    q_a.delete();
    q_b.delete();
    tick();
    push(8'd69, 8'd16);
    start_job(8'd1);
    void'(model_job(1));
    wait_result("after_reset");
    n_cmp++;
    if (bus.res_data !== 32'd1104 || bus.res_count !== 8'd1) begin
      n_bad++;
      $display("FAIL after_reset_job: got %0d/%0d expected 1104/1", bus.res_data, bus.res_count);
    end
    accept();
  endtask

  task automatic test_wrap();
    logic ok;
    for (int i = 0; i < 2; i++) begin
      bus2.in_valid = 1'b1;
      bus2.in_a     = 8'd255;
      bus2.in_b     = 8'd255;
      tick();
    end
    bus2.in_valid = 1'b0;
    bus2.start    = 1'b1;
    bus2.cfg_len  = 8'd2;
    tick();
    bus2.start    = 1'b0;
    for (int k = 0; k < 2; k++) begin
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
        if (bus2.pe_en === 1'b1) begin
          ok = 1'b1;
          break;
        end
        tick();
      end
      n_cmp++;
      if (!ok) begin
        n_bad++;
        $display("FAIL wrap_issue%0d: got pe_en=0 expected 1", k);
      end
      tick();
      bus2.pe_c    = 16'd65025;
      bus2.pe_done = 1'b1;
      tick();
      bus2.pe_done = 1'b0;
    end
    n_cmp++;
`ifdef ACC_SAT_EN
    if (bus2.res_valid !== 1'b1 || bus2.res_data !== 16'd65535 || bus2.res_ovf !== 1'b1) begin
      n_bad++;
      $display("FAIL sat_sum: got valid=%b data=%0d ovf=%b expected 1/65535/1", bus2.res_valid, bus2.res_data, bus2.res_ovf);
    end
`else
    if (bus2.res_valid !== 1'b1 || bus2.res_data !== 16'd64514) begin
      n_bad++;
      $display("FAIL wrap_sum: got valid=%b data=%0d expected 1/64514", bus2.res_valid, bus2.res_data);
    end
`endif
    bus2.res_ready = 1'b1;
    tick();
    bus2.res_ready = 1'b0;
  endtask

  initial begin
    bus.start = 1'b0;  bus.cfg_len = '0;  bus.in_valid = 1'b0;  bus.in_a = '0;  bus.in_b = '0;  bus.res_ready = 1'b0;
    bus2.start = 1'b0; bus2.cfg_len = '0; bus2.in_valid = 1'b0; bus2.in_a = '0; bus2.in_b = '0; bus2.res_ready = 1'b0;
    bus2.pe_done = 1'b0; bus2.pe_c = '0;
    test_reset();
    test_basic();
    test_extremes();
    test_stall();
    test_fill();
    test_zero();
    test_ignore();
    test_random();
    test_reset_mid();
    test_wrap();
    n_cmp++;
    if (pe_bad != 0) begin
      n_bad++;
      $display("FAIL pe_protocol: got %0d violations expected 0", pe_bad);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
